alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; power of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; not overridden independently of WIDTH.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when in_valid=1.
REQ-007 SHALL have port op  input  3  operation: 000 ADD, 001 LHB, 010 SUB, 011 AND, 100 NOR, 101 SLL, 110 SRL, 111 SRA.
REQ-008 SHALL have port sat_en  input  1  saturate ADD/SUB on overflow.
REQ-009 SHALL have port set_flags  input  1  request updates flags on retirement.
REQ-010 SHALL have port src0, src1  input  WIDTH each  operands.
REQ-011 SHALL have port shamt  input  SHW  shift amount.
REQ-012 SHALL have port out_valid  output  1  result present on dst.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port dst  output  WIDTH  result.
REQ-015 SHALL have ports v, z, n  output  1 each  registered overflow, zero, negative flags.

Function
REQ-016 SHALL be a two-stage pipeline: S1 registers request (op, sat_en, set_flags, src0, src1, shamt); S2 registers computed dst and its flag candidates.
REQ-017 SHALL accept a request on a cycle with in_valid=1 and in_ready=1; dst/out_valid for it appear 2 cycles later with no stall.
REQ-018 SHALL drive in_ready = !s1_valid || s1 advances; S1 advances when !s2_valid || out_ready.
REQ-019 SHALL retire a result on out_valid=1 and out_ready=1; full throughput of one op per cycle when out_ready stays 1.
REQ-020 SHALL hold dst and out_valid stable while out_valid=1 and out_ready=0; no result dropped, duplicated or reordered.
REQ-021 SHALL compute: ADD src0+src1; SUB src0-src1; AND src0&src1; NOR ~(src0|src1); SLL src1<<shamt; SRL src1>>shamt (zero fill); SRA src1>>>shamt (sign fill); LHB {src1 upper WIDTH/2 bits, src0 lower WIDTH/2 bits}; all modulo 2^WIDTH.
REQ-022 SHALL detect ADD overflow when src0, src1 MSBs equal and raw sum MSB differs; SUB overflow when src0, src1 MSBs differ and raw difference MSB differs from src0 MSB.
REQ-023 SHALL, when sat_en=1 and overflow, output 0 followed by WIDTH-1 ones if src0 MSB=0, else 1 followed by WIDTH-1 zeros; sat_en=0 outputs wrapped value.
REQ-024 SHALL update flags only at retirement of a request with set_flags=1; otherwise v, z, n hold.
REQ-025 SHALL on such retirement assign z = (dst==0) for every op; for ADD/SUB also assign v = overflow (independent of sat_en) and n = dst MSB; for other ops v, n hold.
REQ-026 SHALL assign flags (set and clear), not accumulate them.
REQ-027 SHALL ignore op/src/shamt values while in_valid=0 or in_ready=0.

Reset
REQ-028 SHALL on rst_n=0 immediately clear both stage valids, out_valid=0, v=z=n=0, in_ready=1 after release; dst reset value 0.
REQ-029 SHALL discard in-flight requests on reset mid-operation; none retire after release.
REQ-030 SHALL accept a new request on the first rising edge after rst_n deasserts.

Verification (WIDTH=16)
REQ-031 ADD 0x7FFF+0x0001, sat_en=1, set_flags=1 -> dst 0x7FFF, v=1 n=0 z=0; same with sat_en=0 -> dst 0x8000, v=1 n=1 z=0.
REQ-032 SUB 0x8000-0x0001, sat_en=1 -> dst 0x8000, v=1 n=1; then ADD 0x0001+0xFFFF, set_flags=1 -> dst 0x0000, z=1 v=0 n=0.
REQ-033 SRA src1=0x8888 shamt=4 -> 0xF888; SRL -> 0x0888; SLL shamt=15 src1=0x0001 -> 0x8000; LHB src0=0x1234 src1=0xABCD -> 0xAB34; AND with set_flags=1 after v=1 -> v unchanged.
REQ-034 Back-to-back 4 requests, out_ready=0 -> in_ready drops after 2 accepted; out_ready=1 -> all 4 results in issue order, none lost.
REQ-035 Assert rst_n=0 with both stages full -> out_valid=0, flags 0 immediately; no stale result after release.
REQ-036 Random ops, random in_valid/out_ready vs. reference model -> dst and flags match at each retirement.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control, optional ADD/SUB
// saturation and registered V/Z/N flags that update when a result retires.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             sat_en,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dst,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int MSB = WIDTH - 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LHB = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    // Saturation limit chosen by the sign of src0: overflow always runs away from it.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic             s1_sat_r;
    logic             s1_setf_r;
    logic [WIDTH-1:0] s1_src0_r;
    logic [WIDTH-1:0] s1_src1_r;
    logic [SHW-1:0]   s1_shamt_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] dst_r;
    logic             s2_setf_r;
    logic             s2_arith_r;
    logic             s2_v_r;
    logic             s2_z_r;
    logic             s2_n_r;
    logic             v_r;
    logic             z_r;
    logic             n_r;

    logic             s1_adv_s;
    logic             in_fire_s;
    logic             retire_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] res_s;
    logic             ovf_s;
    logic             arith_s;

    assign s1_adv_s  = !s2_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || s1_adv_s;
    assign in_fire_s = in_valid && in_ready;
    assign retire_s  = s2_valid_r && out_ready;

    assign out_valid = s2_valid_r;
    assign dst       = dst_r;
    assign v         = v_r;
    assign z         = z_r;
    assign n         = n_r;

    // Stage-1 datapath: compute the result and overflow for the held request.
    always_comb begin
        sum_s     = s1_src0_r + s1_src1_r;
        diff_s    = s1_src0_r - s1_src1_r;
        add_ovf_s = (s1_src0_r[MSB] == s1_src1_r[MSB]) && (sum_s[MSB] != s1_src0_r[MSB]);
        sub_ovf_s = (s1_src0_r[MSB] != s1_src1_r[MSB]) && (diff_s[MSB] != s1_src0_r[MSB]);
        res_s     = {WIDTH{1'b0}};
        ovf_s     = 1'b0;
        arith_s   = 1'b0;
        case (s1_op_r)
            OP_ADD: begin
                arith_s = 1'b1;
                ovf_s   = add_ovf_s;
                if (s1_sat_r && add_ovf_s) begin
                    res_s = sat_value(s1_src0_r[MSB]);
                end else begin
                    res_s = sum_s;
                end
            end
            OP_SUB: begin
                arith_s = 1'b1;
                ovf_s   = sub_ovf_s;
                if (s1_sat_r && sub_ovf_s) begin
                    res_s = sat_value(s1_src0_r[MSB]);
                end else begin
                    res_s = diff_s;
                end
            end
            OP_LHB:  res_s = {s1_src1_r[MSB:WIDTH/2], s1_src0_r[WIDTH/2-1:0]};
            OP_AND:  res_s = s1_src0_r & s1_src1_r;
            OP_NOR:  res_s = ~(s1_src0_r | s1_src1_r);
            OP_SLL:  res_s = s1_src1_r << s1_shamt_r;
            OP_SRL:  res_s = s1_src1_r >> s1_shamt_r;
            OP_SRA:  res_s = $signed(s1_src1_r) >>> s1_shamt_r;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Stage-1 register: capture a request whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'b000;
            s1_sat_r   <= 1'b0;
            s1_setf_r  <= 1'b0;
            s1_src0_r  <= {WIDTH{1'b0}};
            s1_src1_r  <= {WIDTH{1'b0}};
            s1_shamt_r <= {SHW{1'b0}};
        end else begin
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (in_fire_s) begin
                s1_op_r    <= op;
                s1_sat_r   <= sat_en;
                s1_setf_r  <= set_flags;
                s1_src0_r  <= src0;
                s1_src1_r  <= src1;
                s1_shamt_r <= shamt;
            end
        end
    end

    // Stage-2 register: result and flag candidates, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            dst_r      <= {WIDTH{1'b0}};
            s2_setf_r  <= 1'b0;
            s2_arith_r <= 1'b0;
            s2_v_r     <= 1'b0;
            s2_z_r     <= 1'b0;
            s2_n_r     <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                dst_r      <= res_s;
                s2_setf_r  <= s1_setf_r;
                s2_arith_r <= arith_s;
                s2_v_r     <= ovf_s;
                s2_z_r     <= (res_s == {WIDTH{1'b0}});
                s2_n_r     <= res_s[MSB];
            end
        end
    end

    // Architectural flags: assigned only when a set_flags result retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= 1'b0;
            z_r <= 1'b0;
            n_r <= 1'b0;
        end else if (retire_s && s2_setf_r) begin
            z_r <= s2_z_r;
            if (s2_arith_r) begin
                v_r <= s2_v_r;
                n_r <= s2_n_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a driver pushes expected results on acceptance,
// a monitor pops and checks dst and the flags that follow each retirement.
module tb_alu_pipe;

    localparam logic [2:0] ADD = 3'd0, LHB = 3'd1, SUB = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] NOR = 3'd4, SLL = 3'd5, SRL = 3'd6, SRA = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sat_en, set_flags;
    logic [2:0]  op;
    logic [15:0] src0, src1, dst;
    logic [3:0]  shamt;
    logic        out_valid, out_ready, v, z, n;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sat_en(sat_en), .set_flags(set_flags), .src0(src0), .src1(src1),
        .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready), .dst(dst),
        .v(v), .z(z), .n(n)
    );

    typedef struct {
        logic [2:0] op; logic sat; logic sf;
        logic [15:0] a; logic [15:0] b; logic [3:0] sh;
        logic [15:0] edst; logic eovf;
    } vec_t;
    typedef struct { logic [15:0] dst; logic [2:0] vzn; } exp_t;

    vec_t stim_q[$];
    exp_t exp_q[$];
    int   tests = 0, fails = 0, acc = 0, acc0;
    logic gate_en = 1'b0, rnd_phase = 1'b0;
    logic fv = 1'b0, fz = 1'b0, fn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic s, input logic f,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] h, input logic [15:0] d, input logic ov);
        vec_t t;
        t.op = o; t.sat = s; t.sf = f; t.a = a; t.b = b; t.sh = h; t.edst = d; t.eovf = ov;
        return t;
    endfunction

    // Reference model based on signed integer range checks.
    function automatic vec_t mkr(input logic [2:0] o, input logic s, input logic f,
                                 input logic [15:0] a, input logic [15:0] b, input logic [3:0] h);
        vec_t t;
        int   r;
        t = mk(o, s, f, a, b, h, 16'h0000, 1'b0);
        r = 0;
        case (o)
            ADD, SUB: begin
                if (o == ADD) r = int'($signed(a)) + int'($signed(b));
                else          r = int'($signed(a)) - int'($signed(b));
                t.eovf = (r > 32767) || (r < -32768);
                t.edst = (t.eovf && s) ? ((r > 0) ? 16'h7FFF : 16'h8000) : r[15:0];
            end
            LHB:     t.edst = {b[15:8], a[7:0]};
            AND_:    t.edst = a & b;
            NOR:     t.edst = ~(a | b);
            SLL:     t.edst = b << h;
            SRL:     t.edst = b >> h;
            SRA:     t.edst = $signed(b) >>> h;
            default: t.edst = 16'h0000;
        endcase
        return t;
    endfunction

    task automatic push_exp(input vec_t t);
        exp_t e;
        if (t.sf) begin
            fz = (t.edst == 16'h0000);
            if (t.op == ADD || t.op == SUB) begin
                fv = t.eovf;
                fn = t.edst[15];
            end
        end
        e.dst = t.edst;
        e.vzn = {fv, fz, fn};
        exp_q.push_back(e);
    endtask

    // Driver: offers the head of stim_q; on acceptance pushes its expected response.
    initial begin
        logic rdy, vld;
        in_valid = 1'b0; op = 3'd0; sat_en = 1'b0; set_flags = 1'b0;
        src0 = 16'h0; src1 = 16'h0; shamt = 4'h0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            vld = in_valid;
            @(posedge clk);
            if (rst_n && vld && rdy && stim_q.size() > 0) begin
                push_exp(stim_q[0]);
                void'(stim_q.pop_front());
                acc++;
            end
            #1;
            if (stim_q.size() > 0 && (!gate_en || $urandom_range(3) != 0)) begin
                in_valid = 1'b1; op = stim_q[0].op; sat_en = stim_q[0].sat;
                set_flags = stim_q[0].sf; src0 = stim_q[0].a; src1 = stim_q[0].b;
                shamt = stim_q[0].sh;
            end else begin
                in_valid = 1'b0; op = 3'($urandom); sat_en = 1'($urandom);
                set_flags = 1'($urandom); src0 = 16'($urandom); src1 = 16'($urandom);
                shamt = 4'($urandom);
            end
        end
    end

    // Monitor: checks each retirement, the flags one edge later, and stall stability.
    initial begin
        logic        pend, hold;
        logic [2:0]  pflags;
        logic [15:0] hold_dst;
        exp_t        e;
        pend = 1'b0; hold = 1'b0; pflags = 3'b000; hold_dst = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                hold = 1'b0;
            end else begin
                if (pend) begin
                    check("flags_vzn", {29'd0, v, z, n}, {29'd0, pflags});
                    pend = 1'b0;
                end
                if (hold) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_dst", {16'd0, dst}, {16'd0, hold_dst});
                end
                hold     = out_valid && !out_ready;
                hold_dst = dst;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got dst %h expected no result", dst);
                    end else begin
                        e = exp_q.pop_front();
                        check("dst", {16'd0, dst}, {16'd0, e.dst});
                        pend   = 1'b1;
                        pflags = e.vzn;
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_phase) out_ready = ($urandom_range(2) != 0);
        end
    end

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check(name, exp_q.size() + stim_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_dst", {16'd0, dst}, 32'd0);
        check("rst_vzn", {29'd0, v, z, n}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        stim_q.push_back(mk(ADD,  1'b1, 1'b1, 16'h7FFF, 16'h0001, 4'd0,  16'h7FFF, 1'b1));
        stim_q.push_back(mk(ADD,  1'b0, 1'b1, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1'b1));
        stim_q.push_back(mk(SUB,  1'b1, 1'b1, 16'h8000, 16'h0001, 4'd0,  16'h8000, 1'b1));
        stim_q.push_back(mk(ADD,  1'b0, 1'b1, 16'h0001, 16'hFFFF, 4'd0,  16'h0000, 1'b0));
        stim_q.push_back(mk(ADD,  1'b0, 1'b1, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1'b1));
        stim_q.push_back(mk(AND_, 1'b0, 1'b1, 16'hF0F0, 16'h0F0F, 4'd0,  16'h0000, 1'b0));
        stim_q.push_back(mk(SRA,  1'b0, 1'b0, 16'h0000, 16'h8888, 4'd4,  16'hF888, 1'b0));
        stim_q.push_back(mk(SRL,  1'b0, 1'b0, 16'h0000, 16'h8888, 4'd4,  16'h0888, 1'b0));
        stim_q.push_back(mk(SLL,  1'b0, 1'b0, 16'h0000, 16'h0001, 4'd15, 16'h8000, 1'b0));
        stim_q.push_back(mk(LHB,  1'b0, 1'b1, 16'h1234, 16'hABCD, 4'd0,  16'hAB34, 1'b0));
        stim_q.push_back(mk(NOR,  1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0,  16'hFFFF, 1'b0));
        stim_q.push_back(mk(SUB,  1'b0, 1'b1, 16'h0005, 16'h0003, 4'd0,  16'h0002, 1'b0));
        stim_q.push_back(mk(SUB,  1'b1, 1'b1, 16'h7FFF, 16'hFFFF, 4'd0,  16'h7FFF, 1'b1));
        stim_q.push_back(mk(ADD,  1'b0, 1'b1, 16'h8000, 16'h8000, 4'd0,  16'h0000, 1'b1));
        stim_q.push_back(mk(ADD,  1'b1, 1'b1, 16'h8000, 16'h8000, 4'd0,  16'h8000, 1'b1));
        stim_q.push_back(mk(SRA,  1'b0, 1'b1, 16'h0000, 16'h7000, 4'd15, 16'h0000, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        drain("directed_drain");

        // Stall: with the consumer blocked only two requests fit in the pipe.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        acc0 = acc;
        stim_q.push_back(mk(ADD, 1'b0, 1'b1, 16'h0001, 16'h0002, 4'd0, 16'h0003, 1'b0));
        stim_q.push_back(mk(SUB, 1'b0, 1'b1, 16'h0000, 16'h0001, 4'd0, 16'hFFFF, 1'b0));
        stim_q.push_back(mk(NOR, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 4'd0, 16'h0000, 1'b0));
        stim_q.push_back(mk(ADD, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 4'd0, 16'hFFFE, 1'b1));
        repeat (8) @(posedge clk);
        #2;
        check("stall_accepted", acc - acc0, 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        drain("stall_drain");

        // Reset with both stages full: everything in flight is discarded.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        stim_q.push_back(mk(AND_, 1'b0, 1'b1, 16'h00FF, 16'h0F0F, 4'd0, 16'h000F, 1'b0));
        stim_q.push_back(mk(SUB,  1'b0, 1'b1, 16'h0003, 16'h0003, 4'd0, 16'h0000, 1'b0));
        repeat (4) @(posedge clk);
        #2;
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_vzn", {29'd0, v, z, n}, 32'd0);
        check("midrst_dst", {16'd0, dst}, 32'd0);
        stim_q.delete();
        exp_q.delete();
        fv = 1'b0; fz = 1'b0; fn = 1'b0;
        out_ready = 1'b1;
        stim_q.push_back(mk(ADD, 1'b0, 1'b1, 16'h0002, 16'h0003, 4'd0, 16'h0005, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc0 = acc;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        check("first_edge_accept", acc - acc0, 32'd1);
        drain("post_rst_drain");

        // Random ops with random in_valid gaps and consumer stalls.
        gate_en = 1'b1;
        rnd_phase = 1'b1;
        for (int i = 0; i < 80; i++) begin
            stim_q.push_back(mkr(3'($urandom_range(7)), 1'($urandom), 1'($urandom),
                                 16'($urandom), 16'($urandom), 4'($urandom)));
        end
        drain("random_drain");
        rnd_phase = 1'b0;
        gate_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
